// File: rtl/mux3_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mux3_arb_pkg
// Description : Shared types, select encodings and round-robin helpers for the
//               three-requester channel arbiter (mux3_rr_arbiter).
// Revision    : 1.0 - initial release
//==============================================================================
package mux3_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Requester index; only 0..2 are ever stored.
    typedef logic [1:0] owner_t;

    localparam owner_t SEL_A = 2'b00;
    localparam owner_t SEL_B = 2'b01;
    localparam owner_t SEL_C = 2'b10;

    typedef struct packed {
        logic   found;
        owner_t owner;
    } pick_t;

    // Successor of a requester index, modulo 3.
    function automatic owner_t rr_next(input owner_t o);
        return (o == SEL_C) ? SEL_A : owner_t'(o + 2'd1);
    endfunction

    // First set bit of (req & mask), scanning start, start+1, start+2 mod 3.
    function automatic pick_t rr_pick(input owner_t     start,
                                      input logic [2:0] req,
                                      input logic [2:0] mask);
        pick_t      p;
        owner_t     idx;
        logic [2:0] w_cand;
        w_cand  = req & mask;
        p.found = 1'b0;
        p.owner = SEL_A;
        idx     = start;
        for (int k = 0; k < 3; k++) begin
            if (!p.found && w_cand[idx]) begin
                p.found = 1'b1;
                p.owner = idx;
            end
            idx = rr_next(idx);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux3_1.sv
`default_nettype none
//==============================================================================
// Module      : mux3_1
// Description : 1-bit 3:1 multiplexer. sel 00/01/10 picks a/b/c; the unused
//               code 11 returns 0.
// Ports       : sel [1:0] select, a/b/c data inputs, y selected output
// Revision    : 1.0 - initial release
//==============================================================================
module mux3_1 (
    input  logic [1:0] sel,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux3_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mux3_rr_arbiter
// Description : Round-robin arbiter sharing one 1-bit channel among three
//               requesters. An owner keeps the channel while its request stays
//               high, limited to MAX_HOLD cycles when someone else is waiting.
// Ports       : clk, rst (sync, active high)
//               req[2:0]      request per requester (0=a, 1=b, 2=c)
//               data_in[2:0]  data bit per requester
//               gnt[2:0]      one-hot grant, registered, 000 when idle
//               sel[1:0]      registered mux select, 00 when idle
//               valid         gnt != 000
//               data_out      data_in[sel] through mux3_1
// Revision    : 1.0 - initial release
//==============================================================================
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] data_in,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       data_out
);

    localparam int                c_cnt_w     = $clog2(MAX_HOLD + 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    arb_state_t         r_state;
    owner_t             r_owner;
    owner_t             r_last_owner;
    logic [c_cnt_w-1:0] r_hold_cnt;
    logic [2:0]         r_gnt;

    arb_state_t         w_state_nxt;
    owner_t             w_owner_nxt;
    owner_t             w_last_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         w_gnt_nxt;
    logic [2:0]         w_own_bit;
    pick_t              w_pick_idle;
    pick_t              w_pick_hand;

    assign w_own_bit   = 3'b001 << r_owner;
    assign w_pick_idle = rr_pick(rr_next(r_last_owner), req, 3'b111);
    // Excluding the owner's bit serves both handoff cases: on release the
    // owner's request is already low, on forced rotation it must be skipped.
    assign w_pick_hand = rr_pick(rr_next(r_owner), req, ~w_own_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= SEL_A;
            r_last_owner <= SEL_C;
            r_hold_cnt   <= '0;
            r_gnt        <= 3'b000;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_hold_cnt   <= w_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_cnt_nxt   = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_idle.found) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_idle.owner;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[r_owner]) begin
                    // Release wins over expiry.
                    w_last_nxt = r_owner;
                    w_cnt_nxt  = '0;
                    if (w_pick_hand.found) begin
                        w_owner_nxt = w_pick_hand.owner;
                    end else begin
                        w_state_nxt = IDLE;
                        w_owner_nxt = SEL_A;
                    end
                end else if (r_hold_cnt == c_hold_last) begin
                    // Saturated: hold until a contender appears.
                    if (w_pick_hand.found) begin
                        w_last_nxt  = r_owner;
                        w_owner_nxt = w_pick_hand.owner;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_hold_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = SEL_A;
            end
        endcase
        w_gnt_nxt = (w_state_nxt == GRANT) ? (3'b001 << w_owner_nxt) : 3'b000;
    end

    assign gnt   = r_gnt;
    assign sel   = r_owner;
    assign valid = |r_gnt;

    mux3_1 u_mux (
        .sel (r_owner),
        .a   (data_in[0]),
        .b   (data_in[1]),
        .c   (data_in[2]),
        .y   (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_mux3_rr_arbiter
// Description : Directed-vector bench for mux3_rr_arbiter with MAX_HOLD=4 and
//               MAX_HOLD=1 instances, followed by a random-request soak that
//               checks the grant invariants every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mux3_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst, rst1;
    logic [2:0] req, req1, data_in;
    logic [2:0] gnt, gnt1;
    logic [1:0] sel, sel1;
    logic       valid, valid1, dout, dout1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .sel(sel), .valid(valid), .data_out(dout)
    );

    mux3_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req(req1), .data_in(data_in),
        .gnt(gnt1), .sel(sel1), .valid(valid1), .data_out(dout1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic [2:0] g,
                           input logic [1:0] s, input logic v);
        chk({tag, "_gnt"},   int'(gnt),   int'(g));
        chk({tag, "_sel"},   int'(sel),   int'(s));
        chk({tag, "_valid"}, int'(valid), int'(v));
    endtask

    function automatic int gidx(input logic [2:0] g);
        case (g)
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 0;
        endcase
    endfunction

    task automatic invariants(input string tag, input logic [2:0] g,
                              input logic [1:0] s, input logic v, input logic d,
                              input logic [2:0] prev_req);
        logic [2:0] w_dv;
        w_dv = data_in;
        chk({tag, "_onehot0"}, int'($countones(g) <= 1), 1);
        chk({tag, "_valid"},   int'(v), int'(|g));
        chk({tag, "_sel"},     int'(s), gidx(g));
        chk({tag, "_noreq"},   int'(g & ~prev_req), 0);
        chk({tag, "_dout"},    int'(d), int'(w_dv[s]));
    endtask

    initial begin
        logic [2:0] exp_g;
        rst = 1'b1; rst1 = 1'b1;
        req = 3'b000; req1 = 3'b000; data_in = 3'b000;
        tick; tick;
        expect4("reset", 3'b000, 2'd0, 1'b0);

        // Single requester 0.
        rst = 1'b0; req = 3'b001; data_in = 3'b001;
        tick; expect4("r0_c1", 3'b001, 2'd0, 1'b1);
        chk("r0_dout1", int'(dout), 1);
        tick; expect4("r0_c2", 3'b001, 2'd0, 1'b1);
        tick; expect4("r0_c3", 3'b001, 2'd0, 1'b1);
        data_in = 3'b000; #1;
        chk("r0_dout0", int'(dout), 0);
        req = 3'b000;
        tick; expect4("r0_idle", 3'b000, 2'd0, 1'b0);

        // Full contention after reset: 001x4, 010x4, 100x4, 001.
        rst = 1'b1; tick; rst = 1'b0; req = 3'b111;
        for (int i = 0; i < 13; i++) begin
            exp_g = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001;
            tick;
            chk($sformatf("rr_c%0d_gnt", i), int'(gnt), int'(exp_g));
            chk($sformatf("rr_c%0d_valid", i), int'(valid), 1);
        end

        // Owner 0 releases, 1 takes over and saturates, then loses to 0.
        req = 3'b010;
        tick; expect4("sat_take", 3'b010, 2'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("sat_c%0d_gnt", i), int'(gnt), 3'b010);
        end
        req = 3'b011;
        tick; expect4("sat_rot", 3'b001, 2'd0, 1'b1);

        // Owner 0 drops with 2 pending: direct handoff, then idle.
        req = 3'b101;
        tick; chk("hand_hold_gnt", int'(gnt), 3'b001);
        req = 3'b100;
        tick; expect4("hand_c", 3'b100, 2'd2, 1'b1);
        data_in = 3'b100; #1;
        chk("hand_dout", int'(dout), 1);
        req = 3'b000;
        tick; expect4("hand_idle", 3'b000, 2'd0, 1'b0);

        // Release and a new request on the same edge.
        req = 3'b010;
        tick; chk("simul_b_gnt", int'(gnt), 3'b010);
        req = 3'b001;
        tick; expect4("simul_a", 3'b001, 2'd0, 1'b1);

        // Reset mid-grant, then first grant goes back to requester 0.
        req = 3'b111;
        tick; chk("mrst_pre_gnt", int'(gnt), 3'b001);
        rst = 1'b1;
        tick; expect4("mrst", 3'b000, 2'd0, 1'b0);
        rst = 1'b0;
        tick; expect4("mrst_after", 3'b001, 2'd0, 1'b1);

        // MAX_HOLD=1: rotate every cycle between 1 and 2.
        rst1 = 1'b0; req1 = 3'b110;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("mh1_c%0d_gnt", i), int'(gnt1), (i % 2 == 0) ? 3'b010 : 3'b100);
        end

        // Random-request soak on both instances.
        for (int c = 0; c < 300; c++) begin
            logic [2:0] pr, pr1;
            req     = 3'($urandom_range(0, 7));
            req1    = 3'($urandom_range(0, 7));
            data_in = 3'($urandom_range(0, 7));
            pr  = req;
            pr1 = req1;
            tick;
            invariants("soak4", gnt, sel, valid, dout, pr);
            invariants("soak1", gnt1, sel1, valid1, dout1, pr1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
